dt_res_reader: RTL
==================

# dt_res_reader

Readback engine for the distance-transform result memory. After the transform engine raises `done`, this block scans the 128x128 result RAM in raster order over the `res_rd`/`res_addr`/`res_di` port and streams every pixel out on a valid/ready interface. It accumulates image statistics (maximum distance, non-zero count and sum) as pixels are accepted. It sits between the result RAM and the host/checker side of the design.

## Interface
- `IMG_LOG2`, 7: log2 of the image edge; image is 2^IMG_LOG2 square, address is `{y,x}`.
- `DATA_W`, 8: result pixel width.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a scan; ignored while `busy`=1.
- `busy`  out  1  high from the cycle after an accepted `start` until the last pixel is accepted.
- `done`  out  1  level; high after the last pixel is accepted, cleared by the next accepted `start`.
- `res_rd`  out  1  read strobe to the result RAM.
- `res_addr`  out  2*IMG_LOG2  read address, `{y[6:0],x[6:0]}`.
- `res_di`  in  DATA_W  read data, valid exactly one cycle after `res_rd`.
- `out_valid`  out  1  pixel available.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `out_data`  out  DATA_W  pixel value.
- `out_x`, `out_y`  out  IMG_LOG2 each  pixel coordinates.
- `out_last`  out  1  high with pixel (127,127).
- `stat_max`  out  DATA_W  maximum accepted value.
- `stat_nz`  out  2*IMG_LOG2+1  count of accepted non-zero pixels; maximum 16384.
- `stat_sum`  out  2*IMG_LOG2+DATA_W  sum of accepted values.

## Operation
- Reset values: all outputs 0; state IDLE; read address counter 0; FIFO empty; statistics 0.
- States:
  - IDLE: waits for `start`. On `start`, clear statistics and address, clear `done`, go to RUN.
  - RUN: issues reads, one address per cycle, while `occupancy + inflight < 2`. The address increments by 1 and wraps x into y naturally. After the address-16383 read is issued, go to DRAIN.
  - DRAIN: no reads. Go to DONE when the pixel with `out_last` is accepted.
  - DONE: `done`=1, `busy`=0. Return to IDLE; `start` is accepted directly from DONE.
- Returning data is written into a 2-entry FIFO together with its coordinates. Coordinates are carried alongside each read; they are not recomputed at the output.
- `out_*` are driven from the FIFO head, registered. `out_valid` = FIFO not empty.
- On each handshake:
  - `stat_max` = max(stat_max, data).
  - `stat_nz` increments if data != 0.
  - `stat_sum` += data, zero-extended.
  - Statistics never saturate; widths are sized to hold the full-image worst case.
- `start` asserted during RUN or DRAIN is ignored; the scan continues unchanged.
- Reset mid-scan returns the block to reset values. Any in-flight read data is discarded.

## Timing
- Latency from `start` to the first `res_rd`: 1 cycle, in the first RUN cycle. First `out_valid` follows 2 cycles after `start`.
- With `out_ready` held at 1, throughput is one pixel per cycle. The full scan ends with `done` rising 16386 cycles after the `start` cycle.
- `out_valid` and the `out_*` fields stay stable while `out_ready`=0. No pixel is dropped or duplicated.
- With `out_ready`=0, at most 2 reads are outstanding. `res_rd` deasserts within the cycle the credit reaches 0.
- `res_addr` is 0 whenever `res_rd`=0.
- Statistics update in the cycle after each handshake. They are final in the same cycle `done` rises.

## Structure
- Shared package `dt_pkg`:
  - `IMG_LOG2`, `DATA_W` constants.
  - Typedefs `pix_t`, `coord_t`, and `addr_t` = `{coord_t y, coord_t x}`.
  - State enum `rd_state_t`.
- Sub-module `dt_skid_fifo`: 2-deep FIFO carrying `{data, x, y, last}`, with `push`/`pop`/`count`. It is reused by future stream blocks.
- Top level holds the FSM, the address/credit counters and the statistics accumulators.

## Test plan
- All-zero RAM, `out_ready`=1:
  - 16384 pixels of 0 in raster order; `out_last` only at (127,127).
  - `stat_max`=0, `stat_nz`=0, `stat_sum`=0.
  - `done` rises 16386 cycles after `start`.
- RAM[a]=a[7:0]:
  - Output data matches the address pattern at every pixel.
  - `stat_max`=255, `stat_nz`=16320, `stat_sum`=2088960.
- Random `out_ready` at 30% duty: the output sequence is identical to the ready=1 run; `res_rd` never leaves more than 2 reads outstanding.
- `out_ready` held 0 for 100 cycles at pixel (5,3): `out_*` hold the (5,3) value; exactly 2 reads issued; the scan resumes correctly.
- `start` pulsed mid-scan: ignored; the final statistics equal those of an uninterrupted run. A `start` after `done` rescans and clears the statistics first.
- `reset` asserted at pixel 8000: all outputs return to 0 immediately; a new `start` yields a full, correct 16384-pixel scan.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared types and constants for the distance-transform result path.
// Addresses are raster order {y, x}; stream entries carry coordinates with the data.
package dt_pkg;

    localparam int IMG_LOG2 = 7;
    localparam int DATA_W   = 8;

    typedef logic [DATA_W-1:0]            pix_t;
    typedef logic [IMG_LOG2-1:0]          coord_t;
    typedef logic [2*IMG_LOG2:0]          nz_t;
    typedef logic [2*IMG_LOG2+DATA_W-1:0] sum_t;

    typedef struct packed {
        coord_t y;
        coord_t x;
    } addr_t;

    typedef struct packed {
        pix_t   data;
        coord_t x;
        coord_t y;
        logic   last;
    } pix_ent_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;

    function automatic addr_t addr_inc(input addr_t a);
        return addr_t'(a + 1'b1);
    endfunction

endpackage

// File: rtl/dt_res_reader_if.sv
// Result-RAM read port plus the pixel output stream of the readback engine.
// The reader is the master of both; the RAM/consumer side is the slave.
interface dt_res_reader_if;
    import dt_pkg::*;

    logic   res_rd;
    addr_t  res_addr;
    pix_t   res_di;

    logic   out_valid;
    logic   out_ready;
    pix_t   out_data;
    coord_t out_x;
    coord_t out_y;
    logic   out_last;

    modport master (
        output res_rd, res_addr,
        input  res_di,
        output out_valid, out_data, out_x, out_y, out_last,
        input  out_ready
    );

    modport slave (
        input  res_rd, res_addr,
        output res_di,
        input  out_valid, out_data, out_x, out_y, out_last,
        output out_ready
    );

endinterface

// File: rtl/dt_skid_fifo.sv
// Two-entry fall-through FIFO of pixel entries: an entry pushed into an empty
// FIFO is visible at the head in the same cycle and can be popped straight away.
module dt_skid_fifo
    import dt_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  pix_ent_t push_ent,
    input  logic     pop,
    output logic     head_valid,
    output pix_ent_t head,
    output logic [1:0] count
);

    localparam int DEPTH = 2;

    pix_ent_t   mem_q [DEPTH];
    pix_ent_t   mem_d [DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       store;
    logic       drop;

    always_comb begin
        head_valid = (count_q != 2'd0) || push;
        head       = '0;
        if (count_q != 2'd0) begin
            head = mem_q[rd_ptr_q];
        end else if (push) begin
            head = push_ent;
        end

        // A push that is popped in the same cycle from an empty FIFO never lands
        drop     = pop && (count_q != 2'd0);
        store    = push && !(pop && (count_q == 2'd0));
        count_d  = count_q + {1'b0, store} - {1'b0, drop};
        wr_ptr_d = wr_ptr_q ^ store;
        rd_ptr_d = rd_ptr_q ^ drop;

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (store && (wr_ptr_q == 1'(i))) begin
                mem_d[i] = push_ent;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dt_res_reader.sv
// Raster-order readback of the distance-transform result RAM into a valid/ready
// pixel stream, with running max / non-zero count / sum statistics.
module dt_res_reader
    import dt_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    dt_res_reader_if.master bus,
    output pix_t stat_max,
    output nz_t  stat_nz,
    output sum_t stat_sum
);

    rd_state_t state_q, state_d;
    addr_t     addr_q, addr_d;
    logic      infl_q, infl_d;
    addr_t     infl_addr_q, infl_addr_d;
    pix_t      max_q, max_d;
    nz_t       nz_q, nz_d;
    sum_t      sum_q, sum_d;

    logic       rd_en;
    logic       pop;
    logic       head_valid;
    pix_ent_t   head;
    pix_ent_t   push_ent;
    logic [1:0] fifo_count;

    // Read data returns one cycle after the strobe; its coordinates ride along
    assign push_ent = '{data: bus.res_di,
                        x:    infl_addr_q.x,
                        y:    infl_addr_q.y,
                        last: (infl_addr_q == addr_t'('1))};

    dt_skid_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (infl_q),
        .push_ent   (push_ent),
        .pop        (pop),
        .head_valid (head_valid),
        .head       (head),
        .count      (fifo_count)
    );

    always_comb begin
        // Credit: stored entries plus the read whose data is arriving must leave room
        rd_en = (state_q == ST_RUN) &&
                (({1'b0, fifo_count} + {2'b00, infl_q}) < 3'd2);
        pop   = head_valid && bus.out_ready;

        state_d     = state_q;
        addr_d      = addr_q;
        infl_d      = rd_en;
        infl_addr_d = rd_en ? addr_q : addr_t'('0);
        max_d       = max_q;
        nz_d        = nz_q;
        sum_d       = sum_q;

        if (rd_en) begin
            addr_d = addr_inc(addr_q);
        end

        if (pop) begin
            if (head.data > max_q) begin
                max_d = head.data;
            end
            if (head.data != '0) begin
                nz_d = nz_q + 1'b1;
            end
            sum_d = sum_q + sum_t'(head.data);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = '0;
                    max_d   = '0;
                    nz_d    = '0;
                    sum_d   = '0;
                end
            end
            ST_RUN: begin
                if (rd_en && (addr_q == addr_t'('1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head.last) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
            max_q       <= '0;
            nz_q        <= '0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            infl_q      <= infl_d;
            infl_addr_q <= infl_addr_d;
            max_q       <= max_d;
            nz_q        <= nz_d;
            sum_q       <= sum_d;
        end
    end

    assign bus.res_rd    = rd_en;
    assign bus.res_addr  = rd_en ? addr_q : addr_t'('0);
    assign bus.out_valid = head_valid;
    assign bus.out_data  = head.data;
    assign bus.out_x     = head.x;
    assign bus.out_y     = head.y;
    assign bus.out_last  = head.last;

    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign stat_max = max_q;
    assign stat_nz  = nz_q;
    assign stat_sum = sum_q;

endmodule
